// File: rtl/multi_cycle_control.sv
// Main control FSM for the multi-cycle datapath: sequences fetch/decode/execute/memory/writeback
// per opcode, stalls on the memory handshake and halts on an illegal opcode or a memory timeout.
module multi_cycle_control #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       memReady,
    input  logic       aluZero,
    input  logic       aluLess,
    output logic       pcWrite,
    output logic       irWrite,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       regWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [3:0] aluOp,
    output logic       aluSwap,
    output logic [1:0] pcSrc,
    output logic       halted,
    output logic       memTimeout
);

    localparam int unsigned CNT_W = (WAIT_LIMIT == 0) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_EXEC_R   = 4'd3;
    localparam logic [3:0] ST_EXEC_I   = 4'd4;
    localparam logic [3:0] ST_WB_ALU   = 4'd5;
    localparam logic [3:0] ST_MEM_ADDR = 4'd6;
    localparam logic [3:0] ST_MEM_RD   = 4'd7;
    localparam logic [3:0] ST_MEM_WB   = 4'd8;
    localparam logic [3:0] ST_MEM_WR   = 4'd9;
    localparam logic [3:0] ST_BRANCH   = 4'd10;
    localparam logic [3:0] ST_JUMP     = 4'd11;
    localparam logic [3:0] ST_HALT     = 4'd12;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ANDI = 4'b0010;
    localparam logic [3:0] OP_ORI  = 4'b0011;
    localparam logic [3:0] OP_SUBI = 4'b0100;
    localparam logic [3:0] OP_J    = 4'b0101;
    localparam logic [3:0] OP_LHW  = 4'b0111;
    localparam logic [3:0] OP_SHW  = 4'b1000;
    localparam logic [3:0] OP_BEQ  = 4'b1001;
    localparam logic [3:0] OP_BNE  = 4'b1010;
    localparam logic [3:0] OP_BLT  = 4'b1011;
    localparam logic [3:0] OP_BGT  = 4'b1100;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d, wait_cnt_inc;
    logic             halted_q, halted_d;
    logic             timeout_q, timeout_d;
    logic             rtype_q, rtype_d;
    logic             mem_state;
    logic             wait_hit;
    logic             enter_mem;

    // Next-state, wait counter and Moore/qualified control decode.
    always_comb begin
        state_d      = state_q;
        rtype_d      = rtype_q;
        timeout_d    = timeout_q;
        halted_d     = halted_q;
        wait_cnt_d   = wait_cnt_q;
        mem_state    = 1'b0;
        enter_mem    = 1'b0;
        wait_cnt_inc = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
        wait_hit     = (WAIT_LIMIT != 0) && (wait_cnt_inc == CNT_LIMIT);

        pcWrite  = 1'b0;
        irWrite  = 1'b0;
        iorD     = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        regWrite = 1'b0;
        regDst   = 1'b0;
        memToReg = 1'b0;
        aluSrcA  = 1'b0;
        aluSrcB  = 2'b00;
        aluOp    = 4'b0000;
        aluSwap  = 1'b0;
        pcSrc    = 2'b00;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_state = 1'b1;
                memRead   = 1'b1;
                aluSrcB   = 2'b01;
                aluOp     = OP_ADDI;
                pcSrc     = 2'b00;
                irWrite   = memReady;
                pcWrite   = memReady;
                if (memReady) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Speculatively form the branch target into ALUOut while dispatching.
                aluSrcB = 2'b10;
                aluOp   = OP_ADDI;
                rtype_d = (opcode == OP_R);
                case (opcode)
                    OP_R:                              state_d = ST_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SUBI: state_d = ST_EXEC_I;
                    OP_LHW, OP_SHW:                    state_d = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE, OP_BLT, OP_BGT:    state_d = ST_BRANCH;
                    OP_J:                              state_d = ST_JUMP;
                    default:                           state_d = ST_HALT;
                endcase
            end
            ST_EXEC_R: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b00;
                aluOp   = OP_R;
                state_d = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                aluSrcA = 1'b1;
                aluOp   = opcode;
                aluSrcB = ((opcode == OP_ANDI) || (opcode == OP_ORI)) ? 2'b11 : 2'b10;
                state_d = ST_WB_ALU;
            end
            ST_WB_ALU: begin
                regWrite = 1'b1;
                regDst   = rtype_q;
                state_d  = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                aluOp   = opcode;
                state_d = (opcode == OP_LHW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                mem_state = 1'b1;
                iorD      = 1'b1;
                memRead   = 1'b1;
                if (memReady) begin
                    state_d = ST_MEM_WB;
                end
            end
            ST_MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_state = 1'b1;
                iorD      = 1'b1;
                memWrite  = 1'b1;
                if (memReady) begin
                    state_d = ST_FETCH;
                end
            end
            ST_BRANCH: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b00;
                aluOp   = opcode;
                pcSrc   = 2'b01;
                aluSwap = (opcode == OP_BGT);
                case (opcode)
                    OP_BEQ:         pcWrite = aluZero;
                    OP_BNE:         pcWrite = !aluZero;
                    OP_BLT, OP_BGT: pcWrite = aluLess;
                    default:        pcWrite = 1'b0;
                endcase
                state_d = ST_FETCH;
            end
            ST_JUMP: begin
                pcSrc   = 2'b10;
                pcWrite = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        // Consecutive stall cycles in a memory state; saturates rather than wrapping.
        if (mem_state) begin
            if (memReady) begin
                wait_cnt_d = '0;
            end else begin
                wait_cnt_d = wait_cnt_inc;
                if (wait_hit) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b1;
                end
            end
        end

        enter_mem = (state_d != state_q) &&
                    ((state_d == ST_FETCH) || (state_d == ST_MEM_RD) || (state_d == ST_MEM_WR));
        if (enter_mem) begin
            wait_cnt_d = '0;
        end

        if (state_d == ST_HALT) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            rtype_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            halted_q   <= halted_d;
            timeout_q  <= timeout_d;
            rtype_q    <= rtype_d;
        end
    end

    assign halted     = halted_q;
    assign memTimeout = timeout_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: an instruction-level model expands each instruction into its
// expected per-cycle control vectors and stimulus, which are replayed against the DUT.
module tb_multi_cycle_control;

    localparam int unsigned WAIT_LIMIT = 4;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ANDI = 4'b0010;
    localparam logic [3:0] OP_ORI  = 4'b0011;
    localparam logic [3:0] OP_SUBI = 4'b0100;
    localparam logic [3:0] OP_J    = 4'b0101;
    localparam logic [3:0] OP_LHW  = 4'b0111;
    localparam logic [3:0] OP_SHW  = 4'b1000;
    localparam logic [3:0] OP_BEQ  = 4'b1001;
    localparam logic [3:0] OP_BNE  = 4'b1010;
    localparam logic [3:0] OP_BLT  = 4'b1011;
    localparam logic [3:0] OP_BGT  = 4'b1100;

    typedef struct packed {
        logic       pcWrite;
        logic       irWrite;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       regWrite;
        logic       regDst;
        logic       memToReg;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [3:0] aluOp;
        logic       aluSwap;
        logic [1:0] pcSrc;
        logic       halted;
        logic       memTimeout;
    } ctl_t;

    typedef struct packed {
        logic       rdy;
        logic       zero;
        logic       less;
        logic [3:0] op;
        ctl_t       want;
    } step_t;

    logic       clk, rst;
    logic [3:0] opcode;
    logic       memReady, aluZero, aluLess;
    logic       pcWrite, irWrite, iorD, memRead, memWrite, regWrite, regDst, memToReg, aluSrcA;
    logic [1:0] aluSrcB, pcSrc;
    logic [3:0] aluOp;
    logic       aluSwap, halted, memTimeout;

    ctl_t  obs;
    step_t plan[$];
    int    checks = 0;
    int    errors = 0;

    assign obs = {pcWrite, irWrite, iorD, memRead, memWrite, regWrite, regDst, memToReg,
                  aluSrcA, aluSrcB, aluOp, aluSwap, pcSrc, halted, memTimeout};

    multi_cycle_control #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .memReady(memReady),
        .aluZero(aluZero), .aluLess(aluLess),
        .pcWrite(pcWrite), .irWrite(irWrite), .iorD(iorD), .memRead(memRead),
        .memWrite(memWrite), .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .aluSwap(aluSwap),
        .pcSrc(pcSrc), .halted(halted), .memTimeout(memTimeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic ctl_t ctl_fetch(input logic rdy);
        ctl_t c = '0;
        c.memRead = 1'b1; c.aluSrcB = 2'b01; c.aluOp = OP_ADDI;
        c.irWrite = rdy;  c.pcWrite = rdy;
        return c;
    endfunction

    function automatic ctl_t ctl_decode();
        ctl_t c = '0;
        c.aluSrcB = 2'b10; c.aluOp = OP_ADDI;
        return c;
    endfunction

    function automatic ctl_t ctl_memaddr(input logic [3:0] op);
        ctl_t c = '0;
        c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.aluOp = op;
        return c;
    endfunction

    function automatic ctl_t ctl_halt(input logic to);
        ctl_t c = '0;
        c.halted = 1'b1; c.memTimeout = to;
        return c;
    endfunction

    function automatic logic [3:0] pick_legal();
        case ($urandom_range(11))
            0:       return OP_R;
            1:       return OP_ADDI;
            2:       return OP_ANDI;
            3:       return OP_ORI;
            4:       return OP_SUBI;
            5:       return OP_J;
            6:       return OP_LHW;
            7:       return OP_SHW;
            8:       return OP_BEQ;
            9:       return OP_BNE;
            10:      return OP_BLT;
            default: return OP_BGT;
        endcase
    endfunction

    task automatic push(input logic rdy, input logic zero, input logic less,
                        input logic [3:0] op, input ctl_t c);
        step_t s;
        s.rdy = rdy; s.zero = zero; s.less = less; s.op = op; s.want = c;
        plan.push_back(s);
    endtask

    task automatic push_halt(input int n, input logic to);
        for (int i = 0; i < n; i++) push(rb(), rb(), rb(), 4'($urandom), ctl_halt(to));
    endtask

    // Expected cycles for one instruction: fw fetch stalls, mw memory stalls.
    task automatic plan_instr(input logic [3:0] op, input int fw, input int mw,
                              input logic zero, input logic less);
        ctl_t c;
        for (int i = 0; i <= fw; i++) push(i == fw, rb(), rb(), 4'($urandom), ctl_fetch(i == fw));
        push(rb(), rb(), rb(), op, ctl_decode());
        if (op == OP_R) begin
            c = '0; c.aluSrcA = 1'b1;
            push(rb(), rb(), rb(), op, c);
            c = '0; c.regWrite = 1'b1; c.regDst = 1'b1;
            push(rb(), rb(), rb(), op, c);
        end else if (op >= OP_ADDI && op <= OP_SUBI) begin
            c = '0; c.aluSrcA = 1'b1; c.aluOp = op;
            c.aluSrcB = (op == OP_ANDI || op == OP_ORI) ? 2'b11 : 2'b10;
            push(rb(), rb(), rb(), op, c);
            c = '0; c.regWrite = 1'b1;
            push(rb(), rb(), rb(), op, c);
        end else if (op == OP_LHW || op == OP_SHW) begin
            push(rb(), rb(), rb(), op, ctl_memaddr(op));
            for (int i = 0; i <= mw; i++) begin
                c = '0; c.iorD = 1'b1;
                if (op == OP_LHW) c.memRead = 1'b1;
                else              c.memWrite = 1'b1;
                push(i == mw, rb(), rb(), op, c);
            end
            if (op == OP_LHW) begin
                c = '0; c.regWrite = 1'b1; c.memToReg = 1'b1;
                push(rb(), rb(), rb(), op, c);
            end
        end else if (op >= OP_BEQ && op <= OP_BGT) begin
            c = '0; c.aluSrcA = 1'b1; c.aluOp = op; c.pcSrc = 2'b01;
            c.aluSwap = (op == OP_BGT);
            c.pcWrite = (op == OP_BEQ) ? zero : (op == OP_BNE) ? !zero : less;
            push(rb(), zero, less, op, c);
        end else if (op == OP_J) begin
            c = '0; c.pcSrc = 2'b10; c.pcWrite = 1'b1;
            push(rb(), rb(), rb(), op, c);
        end else begin
            push_halt(20, 1'b0);
        end
    endtask

    task automatic drive_step(input step_t s);
        @(negedge clk);
        memReady = s.rdy; aluZero = s.zero; aluLess = s.less; opcode = s.op;
        #1;
    endtask

    // Synchronous reset pulse; the DUT sits in IDLE for the following cycle.
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(rb(), rb(), rb(), 4'($urandom), '0);
    endtask

    task automatic test_reset();
        ctl_t want;
        rst = 1'b1; memReady = 1'b0; aluZero = 1'b0; aluLess = 1'b0; opcode = OP_R;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== ctl_t'(0)) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs, ctl_t'(0));
            end
        end
        rst = 1'b0; #1;
        checks++;
        if (obs !== ctl_t'(0)) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", obs, ctl_t'(0));
        end
        @(negedge clk); #1;
        want = ctl_fetch(1'b0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL reset_first_fetch: got %h expected %h", obs, want);
        end
    endtask

    task automatic test_rtype();
        step_t s;
        int n = 0;
        reset_dut();
        plan_instr(OP_R, 0, 0, rb(), rb());
        plan_instr(OP_ADDI, 0, 0, rb(), rb());
        while (plan.size() > 0) begin
            s = plan.pop_front(); drive_step(s); n++;
            checks++;
            if (obs !== s.want) begin
                errors++;
                $display("FAIL rtype step %0d: got %h expected %h", n, obs, s.want);
            end
        end
    endtask

    task automatic test_lhw_stall();
        step_t s;
        int n = 0, rd_cycles = 0, wb_cycles = 0;
        reset_dut();
        plan_instr(OP_LHW, 0, 3, rb(), rb());
        while (plan.size() > 0) begin
            s = plan.pop_front(); drive_step(s); n++;
            if (obs.memRead && obs.iorD) rd_cycles++;
            if (obs.regWrite && obs.memToReg) wb_cycles++;
            checks++;
            if (obs !== s.want) begin
                errors++;
                $display("FAIL lhw_stall step %0d: got %h expected %h", n, obs, s.want);
            end
        end
        checks++;
        if (rd_cycles !== 4) begin
            errors++;
            $display("FAIL lhw_read_cycles: got %0d expected 4", rd_cycles);
        end
        checks++;
        if (wb_cycles !== 1) begin
            errors++;
            $display("FAIL lhw_writeback_cycles: got %0d expected 1", wb_cycles);
        end
    endtask

    task automatic test_branch();
        step_t s;
        int n = 0;
        reset_dut();
        plan_instr(OP_BEQ, 0, 0, 1'b1, rb());
        plan_instr(OP_BEQ, 0, 0, 1'b0, rb());
        plan_instr(OP_BNE, 1, 0, 1'b0, rb());
        plan_instr(OP_BLT, 0, 0, rb(), 1'b1);
        plan_instr(OP_BGT, 0, 0, rb(), 1'b1);
        plan_instr(OP_BGT, 0, 0, rb(), 1'b0);
        plan_instr(OP_J, 2, 0, rb(), rb());
        while (plan.size() > 0) begin
            s = plan.pop_front(); drive_step(s); n++;
            checks++;
            if (obs !== s.want) begin
                errors++;
                $display("FAIL branch step %0d: got %h expected %h", n, obs, s.want);
            end
        end
    endtask

    task automatic test_illegal();
        step_t s;
        logic [3:0] bad;
        int n = 0;
        for (int k = 0; k < 4; k++) begin
            bad = (k == 0) ? 4'b0110 : 4'(4'b1100 + k);
            reset_dut();
            plan_instr(bad, int'($urandom_range(WAIT_LIMIT - 1)), 0, rb(), rb());
        end
        reset_dut();
        while (plan.size() > 0) begin
            s = plan.pop_front(); drive_step(s); n++;
            checks++;
            if (obs !== s.want) begin
                errors++;
                $display("FAIL illegal step %0d: got %h expected %h", n, obs, s.want);
            end
            // A queued reset step starts each new illegal-opcode run.
            if (plan.size() > 0 && plan[0].want == ctl_t'(0) && s.want.halted) begin
                plan.pop_front();
                @(negedge clk); rst = 1'b1;
                @(posedge clk); #1; rst = 1'b0;
                push(1'b0, 1'b0, 1'b0, 4'($urandom), '0);
                plan.push_front(plan.pop_back());
            end
        end
    endtask

    task automatic test_timeout();
        step_t s;
        int n = 0;
        reset_dut();
        for (int i = 0; i < WAIT_LIMIT; i++) push(1'b0, rb(), rb(), 4'($urandom), ctl_fetch(1'b0));
        push_halt(6, 1'b1);
        while (plan.size() > 0) begin
            s = plan.pop_front(); drive_step(s); n++;
            checks++;
            if (obs !== s.want) begin
                errors++;
                $display("FAIL fetch_timeout step %0d: got %h expected %h", n, obs, s.want);
            end
        end
        n = 0;
        reset_dut();
        plan_instr(OP_SHW, 3, WAIT_LIMIT, rb(), rb());
        void'(plan.pop_back());
        push_halt(6, 1'b1);
        while (plan.size() > 0) begin
            s = plan.pop_front(); drive_step(s); n++;
            checks++;
            if (obs !== s.want) begin
                errors++;
                $display("FAIL memwr_timeout step %0d: got %h expected %h", n, obs, s.want);
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t s;
        int n = 0;
        reset_dut();
        plan_instr(OP_SHW, 1, 3, rb(), rb());
        while (plan.size() > 2) begin
            s = plan.pop_front(); drive_step(s); n++;
            checks++;
            if (obs !== s.want) begin
                errors++;
                $display("FAIL reset_mid step %0d: got %h expected %h", n, obs, s.want);
            end
        end
        plan.delete();
        @(negedge clk);
        memReady = 1'b0; rst = 1'b1; #1;
        checks++;
        if (memWrite !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_before: memWrite got %b expected 1", memWrite);
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== ctl_t'(0)) begin
            errors++;
            $display("FAIL reset_mid_after: got %h expected %h", obs, ctl_t'(0));
        end
        rst = 1'b0;
        push(rb(), rb(), rb(), 4'($urandom), '0);
        plan_instr(OP_J, WAIT_LIMIT - 1, 0, rb(), rb());
        while (plan.size() > 0) begin
            s = plan.pop_front(); drive_step(s); n++;
            checks++;
            if (obs !== s.want) begin
                errors++;
                $display("FAIL reset_mid_resume step %0d: got %h expected %h", n, obs, s.want);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s;
        int n = 0;
        reset_dut();
        for (int i = 0; i < 60; i++) begin
            plan_instr(pick_legal(), int'($urandom_range(WAIT_LIMIT - 1)),
                       int'($urandom_range(WAIT_LIMIT - 1)), rb(), rb());
        end
        while (plan.size() > 0) begin
            s = plan.pop_front(); drive_step(s); n++;
            checks++;
            if (obs !== s.want) begin
                errors++;
                $display("FAIL back_to_back step %0d op %h: got %h expected %h", n, s.op, obs, s.want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lhw_stall();
        test_branch();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
